// File: rtl/sram_fifo_ctl_2048x32.sv
// sram_fifo_ctl_2048x32: FIFO controller driving an external synchronous dual-port SRAM.
//
// Ports:
//   sram_clock, sram_reset             single clock, asynchronous active-high reset
//   fifo_push, fifo_push_data          enqueue request and word
//   fifo_pop                           dequeue request
//   fifo_flush                         synchronous clear of contents and pointers
//   fifo_pop_valid, fifo_pop_data      registered dequeued word, valid for one cycle
//   fifo_empty, fifo_full, fifo_count  occupancy (count is 0..2^ADDR_WIDTH)
//   fifo_push_error, fifo_pop_error    one-cycle pulses for rejected requests
//   sram_write, sram_write_address, sram_write_data   SRAM write port
//   sram_read, sram_read_address, sram_read_data      SRAM read port (data one cycle after strobe)
module sram_fifo_ctl_2048x32 #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sram_clock,
    input  logic                  sram_reset,
    input  logic                  fifo_push,
    input  logic [DATA_WIDTH-1:0] fifo_push_data,
    input  logic                  fifo_pop,
    input  logic                  fifo_flush,
    output logic                  fifo_pop_valid,
    output logic [DATA_WIDTH-1:0] fifo_pop_data,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_push_error,
    output logic                  fifo_pop_error,
    output logic                  sram_write,
    output logic [ADDR_WIDTH-1:0] sram_write_address,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    output logic                  sram_read,
    output logic [ADDR_WIDTH-1:0] sram_read_address,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  s1_valid;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags come from the registered count, so they never depend on this cycle's requests.
    assign fifo_empty = fifo_count == '0;
    assign fifo_full  = fifo_count == DEPTH;

    // Strobes are gated by reset so nothing reaches the SRAM while reset is held.
    assign push_ok = fifo_push && !fifo_full && !fifo_flush && !sram_reset;
    assign pop_ok  = fifo_pop && !fifo_empty && !fifo_flush && !sram_reset;

    assign sram_write         = push_ok;
    assign sram_write_address = wr_ptr;
    assign sram_write_data    = fifo_push_data;
    assign sram_read          = pop_ok;
    assign sram_read_address  = rd_ptr;

    always_ff @(posedge sram_clock or posedge sram_reset) begin
        if (sram_reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            s1_valid        <= 1'b0;
            fifo_pop_valid  <= 1'b0;
            fifo_pop_data   <= '0;
            fifo_push_error <= 1'b0;
            fifo_pop_error  <= 1'b0;
        end else begin
            fifo_push_error <= fifo_push && fifo_full && !fifo_flush;
            fifo_pop_error  <= fifo_pop && fifo_empty && !fifo_flush;
            // A flush also drops the read already in flight in the SRAM.
            fifo_pop_valid  <= s1_valid && !fifo_flush;
            if (s1_valid && !fifo_flush)
                fifo_pop_data <= sram_read_data;
            if (fifo_flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                s1_valid   <= 1'b0;
            end else begin
                wr_ptr     <= wr_ptr + ADDR_WIDTH'(push_ok);
                rd_ptr     <= rd_ptr + ADDR_WIDTH'(pop_ok);
                fifo_count <= fifo_count + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
                s1_valid   <= pop_ok;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctl_2048x32.sv
// tb_sram_fifo_ctl_2048x32: directed bench for the SRAM FIFO controller with a behavioural SRAM.
module tb_sram_fifo_ctl_2048x32;

    logic        sram_clock;
    logic        sram_reset;
    logic        fifo_push;
    logic [31:0] fifo_push_data;
    logic        fifo_pop;
    logic        fifo_flush;
    logic        fifo_pop_valid;
    logic [31:0] fifo_pop_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [11:0] fifo_count;
    logic        fifo_push_error;
    logic        fifo_pop_error;
    logic        sram_write;
    logic [10:0] sram_write_address;
    logic [31:0] sram_write_data;
    logic        sram_read;
    logic [10:0] sram_read_address;
    logic [31:0] sram_read_data;

    logic [31:0] mem [0:2047];

    int n_checks = 0;
    int n_fail   = 0;

    sram_fifo_ctl_2048x32 dut (
        .sram_clock         (sram_clock),
        .sram_reset         (sram_reset),
        .fifo_push          (fifo_push),
        .fifo_push_data     (fifo_push_data),
        .fifo_pop           (fifo_pop),
        .fifo_flush         (fifo_flush),
        .fifo_pop_valid     (fifo_pop_valid),
        .fifo_pop_data      (fifo_pop_data),
        .fifo_empty         (fifo_empty),
        .fifo_full          (fifo_full),
        .fifo_count         (fifo_count),
        .fifo_push_error    (fifo_push_error),
        .fifo_pop_error     (fifo_pop_error),
        .sram_write         (sram_write),
        .sram_write_address (sram_write_address),
        .sram_write_data    (sram_write_data),
        .sram_read          (sram_read),
        .sram_read_address  (sram_read_address),
        .sram_read_data     (sram_read_data)
    );

    initial sram_clock = 1'b0;
    always #5 sram_clock = ~sram_clock;

    always @(posedge sram_clock) begin
        if (sram_write)
            mem[sram_write_address] <= sram_write_data;
        if (sram_read)
            sram_read_data <= mem[sram_read_address];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sram_clock);
        #1;
    endtask

    initial begin
        int n_valid;
        int n_err;
        int exp_rd;
        sram_reset     = 1'b1;
        fifo_push      = 1'b1;
        fifo_push_data = 32'h0;
        fifo_pop       = 1'b0;
        fifo_flush     = 1'b0;
        repeat (2) cyc();
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_pop_valid", fifo_pop_valid, 0);
        check("rst_pop_data", fifo_pop_data, 0);
        check("rst_push_err", fifo_push_error, 0);
        check("rst_pop_err", fifo_pop_error, 0);
        check("rst_sram_write", sram_write, 0);
        check("rst_sram_read", sram_read, 0);
        fifo_push  = 1'b0;
        sram_reset = 1'b0;
        cyc();

        // push then pop one word
        fifo_push = 1'b1; fifo_push_data = 32'hA5A50001;
        #1;
        check("p1_write", sram_write, 1);
        check("p1_waddr", sram_write_address, 0);
        check("p1_wdata", sram_write_data, 32'hA5A50001);
        cyc();
        fifo_push = 1'b0; fifo_pop = 1'b1;
        #1;
        check("p1_read", sram_read, 1);
        check("p1_raddr", sram_read_address, 0);
        check("p1_count1", fifo_count, 1);
        cyc();
        fifo_pop = 1'b0;
        check("p1_valid_n1", fifo_pop_valid, 0);
        check("p1_count0", fifo_count, 0);
        check("p1_empty", fifo_empty, 1);
        cyc();
        check("p1_valid_n2", fifo_pop_valid, 1);
        check("p1_data", fifo_pop_data, 32'hA5A50001);
        cyc();
        check("p1_valid_off", fifo_pop_valid, 0);
        check("p1_data_hold", fifo_pop_data, 32'hA5A50001);

        // pop on empty with simultaneous push: no bypass
        fifo_push = 1'b1; fifo_push_data = 32'h12345678; fifo_pop = 1'b1;
        #1;
        check("pe_read", sram_read, 0);
        check("pe_write", sram_write, 1);
        cyc();
        fifo_push = 1'b0; fifo_pop = 1'b0;
        check("pe_pop_err", fifo_pop_error, 1);
        check("pe_push_err", fifo_push_error, 0);
        check("pe_count", fifo_count, 1);
        cyc();
        check("pe_pop_err_off", fifo_pop_error, 0);
        fifo_pop = 1'b1;
        #1;
        check("pe_raddr", sram_read_address, 1);
        cyc();
        fifo_pop = 1'b0;
        cyc();
        check("pe_valid", fifo_pop_valid, 1);
        check("pe_data", fifo_pop_data, 32'h12345678);

        // flush ignores requests in the same cycle
        fifo_push = 1'b1; fifo_pop = 1'b1; fifo_flush = 1'b1;
        #1;
        check("fl_write", sram_write, 0);
        check("fl_read", sram_read, 0);
        cyc();
        fifo_push = 1'b0; fifo_pop = 1'b0; fifo_flush = 1'b0;
        check("fl_push_err", fifo_push_error, 0);
        check("fl_pop_err", fifo_pop_error, 0);
        check("fl_count", fifo_count, 0);

        // fill to full, then overflow
        for (int i = 0; i < 2048; i++) begin
            fifo_push = 1'b1; fifo_push_data = i;
            cyc();
        end
        fifo_push = 1'b0;
        check("full_flag", fifo_full, 1);
        check("full_count", fifo_count, 2048);
        check("full_empty", fifo_empty, 0);
        fifo_push = 1'b1; fifo_push_data = 32'hDEAD0000;
        #1;
        check("ovf_write", sram_write, 0);
        cyc();
        fifo_push = 1'b0;
        check("ovf_push_err", fifo_push_error, 1);
        check("ovf_count", fifo_count, 2048);

        // full with push and pop together
        fifo_push = 1'b1; fifo_pop = 1'b1; fifo_push_data = 32'hBEEF0000;
        #1;
        check("fpp_write", sram_write, 0);
        check("fpp_read", sram_read, 1);
        check("fpp_raddr", sram_read_address, 0);
        cyc();
        fifo_push = 1'b0; fifo_pop = 1'b0;
        check("fpp_push_err", fifo_push_error, 1);
        check("fpp_pop_err", fifo_pop_error, 0);
        check("fpp_count", fifo_count, 2047);
        check("fpp_full", fifo_full, 0);
        cyc();
        check("fpp_valid", fifo_pop_valid, 1);
        check("fpp_data", fifo_pop_data, 0);
        fifo_pop = 1'b1;
        cyc();
        fifo_pop = 1'b0;
        cyc();
        check("fpp_data2", fifo_pop_data, 1);

        // flush one cycle after an accepted pop
        fifo_pop = 1'b1;
        cyc();
        fifo_pop = 1'b0; fifo_flush = 1'b1;
        cyc();
        fifo_flush = 1'b0;
        check("flp_valid1", fifo_pop_valid, 0);
        check("flp_count", fifo_count, 0);
        check("flp_empty", fifo_empty, 1);
        cyc();
        check("flp_valid2", fifo_pop_valid, 0);
        check("flp_data_hold", fifo_pop_data, 1);

        // reset one cycle after an accepted pop
        fifo_push = 1'b1; fifo_push_data = 32'h00000077;
        cyc();
        fifo_push = 1'b0; fifo_pop = 1'b1;
        cyc();
        fifo_pop = 1'b0;
        #2 sram_reset = 1'b1;
        #1;
        check("rsp_async_data", fifo_pop_data, 0);
        check("rsp_async_empty", fifo_empty, 1);
        sram_reset = 1'b0;
        cyc();
        check("rsp_valid1", fifo_pop_valid, 0);
        check("rsp_count", fifo_count, 0);
        check("rsp_empty", fifo_empty, 1);
        cyc();
        check("rsp_valid2", fifo_pop_valid, 0);

        // continuous streaming across pointer wrap
        n_valid = 0; n_err = 0; exp_rd = 0;
        for (int i = 0; i < 5000; i++) begin
            fifo_push = 1'b1; fifo_push_data = 32'hC0000000 + i;
            fifo_pop  = (i > 0);
            cyc();
            if (fifo_push_error || fifo_pop_error) n_err++;
            if (fifo_pop_valid) begin
                check("str_data", fifo_pop_data, 32'hC0000000 + exp_rd);
                exp_rd++;
                n_valid++;
            end
        end
        fifo_push = 1'b0; fifo_pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (fifo_push_error || fifo_pop_error) n_err++;
            if (fifo_pop_valid) begin
                check("str_data", fifo_pop_data, 32'hC0000000 + exp_rd);
                exp_rd++;
                n_valid++;
            end
        end
        check("str_valids", n_valid, 4999);
        check("str_errors", n_err, 0);
        check("str_count", fifo_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctl_2048x32.md
SRAM_FIFO_CTL_2048X32 -- requirements
Module: sram_fifo_ctl_2048x32

Interface
REQ-001 Parameter: ADDR_WIDTH, default 11, SRAM address width; depth is 2^ADDR_WIDTH words.
REQ-002 Parameter: DATA_WIDTH, default 32, word width.
REQ-003 sram_clock  input  1  single clock; all state changes on its rising edge.
REQ-004 sram_reset  input  1  asynchronous, active-high reset.
REQ-005 fifo_push  input  1  write request for fifo_push_data this cycle.
REQ-006 fifo_push_data  input  DATA_WIDTH  word to enqueue.
REQ-007 fifo_pop  input  1  read request this cycle.
REQ-008 fifo_flush  input  1  synchronous clear of FIFO contents.
REQ-009 fifo_pop_valid  output  1  one-cycle pulse; fifo_pop_data holds a dequeued word.
REQ-010 fifo_pop_data  output  DATA_WIDTH  registered dequeued word.
REQ-011 fifo_empty, fifo_full  output  1 each  occupancy flags.
REQ-012 fifo_count  output  ADDR_WIDTH+1  words held, 0..2^ADDR_WIDTH.
REQ-013 fifo_push_error, fifo_pop_error  output  1 each  one-cycle pulses for rejected requests.
REQ-014 sram_write  output  1  SRAM write strobe.
REQ-015 sram_write_address  output  ADDR_WIDTH  SRAM write address.
REQ-016 sram_write_data  output  DATA_WIDTH  SRAM write data.
REQ-017 sram_read  output  1  SRAM read strobe.
REQ-018 sram_read_address  output  ADDR_WIDTH  SRAM read address.
REQ-019 sram_read_data  input  DATA_WIDTH  SRAM read data, valid in the cycle after sram_read.

Function
REQ-020 The block SHALL be the initiator for a synchronous dual-port SRAM: one write port and one read port. The SRAM samples address, strobe and write data on the sram_clock edge. Read data appears one cycle after the read strobe.
REQ-021 Push acceptance: fifo_push && !fifo_full && !fifo_flush. In the same cycle: sram_write=1, sram_write_address=wr_ptr, sram_write_data=fifo_push_data. wr_ptr increments mod 2^ADDR_WIDTH at the edge.
REQ-022 Pop acceptance: fifo_pop && !fifo_empty && !fifo_flush. In the same cycle: sram_read=1, sram_read_address=rd_ptr. rd_ptr increments mod 2^ADDR_WIDTH at the edge.
REQ-023 sram_write and sram_read SHALL be combinational from acceptance and 0 otherwise. Address and data outputs are don't-care when their strobe is 0.
REQ-024 Read pipeline, pop accepted in cycle N: stage1 valid set for cycle N+1. At the end of N+1, sram_read_data is captured into fifo_pop_data. fifo_pop_valid=1 in cycle N+2 only. Pop latency is 2 cycles, with one result per accepted pop at full throughput.
REQ-025 fifo_pop_data SHALL hold its last captured value while fifo_pop_valid=0.
REQ-026 fifo_count is updated at the edge: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither are accepted.
REQ-027 fifo_empty = (fifo_count==0) and fifo_full = (fifo_count==2^ADDR_WIDTH). Both flags are registered-derived, not combinational from requests.
REQ-028 Push when full is rejected even if a pop is accepted in the same cycle. No SRAM write occurs and fifo_push_error pulses in the next cycle.
REQ-029 Pop when empty is rejected even if a push is accepted in the same cycle (no bypass). No SRAM read occurs and fifo_pop_error pulses in the next cycle.
REQ-030 fifo_flush=1 at an edge clears wr_ptr, rd_ptr, fifo_count and stage1 valid. fifo_pop_valid is 0 in the following cycle, and pushes/pops in the flush cycle are ignored with no error pulse.
REQ-031 Pointer wrap from 2^ADDR_WIDTH-1 to 0 SHALL be seamless. Full and empty are distinguished by fifo_count, not by pointer equality.

Reset
REQ-032 While sram_reset=1, asynchronously:
- wr_ptr, rd_ptr, fifo_count = 0
- stage1 valid = 0
- fifo_pop_valid = 0
- fifo_pop_data = 0
- fifo_push_error = 0
- fifo_pop_error = 0
REQ-033 While sram_reset=1: fifo_empty=1, fifo_full=0, sram_write=0, sram_read=0. A reset during an in-flight pop discards it, with no fifo_pop_valid afterwards.

Verification
REQ-034 Push 0xA5A50001 then pop next cycle -> sram_write at addr 0, sram_read at addr 0. fifo_pop_valid with data 0xA5A50001 two cycles after the pop; count returns to 0.
REQ-035 Push 2048 words (value = index), then push again -> fifo_full=1 and count=2048. The extra push produces a fifo_push_error pulse and no sram_write.
REQ-036 Pop on empty with simultaneous push of 0x12345678 -> fifo_pop_error pulse and count=1. The next pop returns 0x12345678.
REQ-037 Continuous push/pop for 5000 cycles crossing address wrap -> in-order data, one fifo_pop_valid per accepted pop, no errors.
REQ-038 Full FIFO with simultaneous push and pop -> pop accepted, push rejected with error, count=2047.
REQ-039 Assert sram_reset or fifo_flush one cycle after a pop is accepted -> no fifo_pop_valid, count=0 and empty=1.
